// File: rtl/pps_timing_pkg.sv
// Shared types and helpers for the PPS timebase and TDC stop controller.
package pps_timing_pkg;

    // Stop controller states: wait for PPS, count guard, wait for tick, stop issued.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        WAIT_TICK = 2'd2,
        DONE      = 2'd3
    } stop_state_e;

    // Width of a tick index for a given number of ticks per second (at least 1 bit).
    function automatic int tick_idx_width(input int ticks_per_sec);
        return (ticks_per_sec > 1) ? $clog2(ticks_per_sec) : 1;
    endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Metastability chain for the raw GPS PPS plus a single-cycle rise detector.
// All flops reset high so a PPS already high at reset release is not a rise.
module pps_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the asynchronous input through the chain and keep one history bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/pps_timebase_stop_ctl.sv
// Local timebase (TOS, clean PPS, slow tick) and single TDC stop aligned to the
// first slow tick at least GUARD_CLKS after a synchronised GPS PPS rise.
// stop_ack is a single-cycle pulse; it clears stop_valid, stop_overrun and
// pps_extra, except that a stop in the same cycle keeps stop_valid set.
module pps_timebase_stop_ctl
    import pps_timing_pkg::*;
#(
    parameter  int CLKS_PER_SEC  = 19200000,
    parameter  int PPS_WIDTH     = 1920,
    parameter  int TICK_PERIOD   = 1920,
    parameter  int SYNC_STAGES   = 2,
    parameter  int GUARD_CLKS    = 96,
    localparam int TICKS_PER_SEC = CLKS_PER_SEC / TICK_PERIOD,
    localparam int TW            = tick_idx_width(TICKS_PER_SEC)
) (
    input  logic          clk_tf,
    input  logic          tf_reset_l,
    input  logic          pps_raw_logic,
    input  logic          stop_ack,
    output logic          tos_mark_ddc,
    output logic          pps_clean_next,
    output logic          pps_clean_uc,
    output logic          slow_tick,
    output logic          tdc_stop_next,
    output logic [TW-1:0] stop_tick_idx,
    output logic          stop_valid,
    output logic          stop_overrun,
    output logic          pps_missing,
    output logic          pps_extra,
    output stop_state_e   stop_state_dbg
);

    localparam int SEC_W  = $clog2(CLKS_PER_SEC);
    localparam int TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int GW     = (GUARD_CLKS > 1) ? $clog2(GUARD_CLKS) : 1;

    localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(CLKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0]  PPS_LAST   = SEC_W'(PPS_WIDTH - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_PERIOD - 1);
    localparam logic [TICK_W-1:0] TICK_HALF  = TICK_W'(TICK_PERIOD / 2);
    localparam logic [TW-1:0]     IDX_LAST   = TW'(TICKS_PER_SEC - 1);
    localparam logic [GW-1:0]     GUARD_LOAD = GW'(GUARD_CLKS - 1);

    if (CLKS_PER_SEC % TICK_PERIOD != 0) begin : g_bad_tick_period
        $error("CLKS_PER_SEC must be a multiple of TICK_PERIOD");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 2");
    end
    if (GUARD_CLKS < 1) begin : g_bad_guard
        $error("GUARD_CLKS must be at least 1");
    end

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TW-1:0]     tick_idx_q, tick_idx_d;
    logic              pps_clean_q, slow_tick_q, slow_tick_d;
    logic              tick_rise_next;
    logic              pps_rise;
    logic [TW-1:0]     stop_idx_next;
    logic              seen_carry;

    stop_state_e       state_q;
    logic [GW-1:0]     guard_q;
    logic              seen_q;
    logic [TW-1:0]     stop_tick_idx_q;
    logic              stop_valid_q, stop_overrun_q, pps_missing_q, pps_extra_q;

    // Reset asserts asynchronously and releases two clk_tf edges later.
    always_ff @(posedge clk_tf or negedge tf_reset_l) begin
        if (!tf_reset_l) rst_sync_q <= 2'b00;
        else             rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    pps_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pps_sync (
        .clk_i   (clk_tf),
        .rst_n_i (rst_n),
        .async_i (pps_raw_logic),
        .rise_o  (pps_rise)
    );

    // Timebase next-state: the tick counter wraps together with the second.
    assign tos_mark_ddc   = (sec_cnt_q == SEC_LAST);
    assign tick_rise_next = (tick_cnt_q == TICK_LAST);
    assign pps_clean_next = (sec_cnt_q < PPS_LAST) || tos_mark_ddc;
    assign sec_cnt_d      = tos_mark_ddc ? '0 : sec_cnt_q + 1'b1;
    assign tick_cnt_d     = tick_rise_next ? '0 : tick_cnt_q + 1'b1;
    assign tick_idx_d     = !tick_rise_next ? tick_idx_q :
                            (tos_mark_ddc ? '0 : tick_idx_q + 1'b1);
    assign slow_tick_d    = (tick_cnt_d < TICK_HALF);
    assign stop_idx_next  = (tick_idx_q == IDX_LAST) ? '0 : tick_idx_q + 1'b1;

    // Free-running second, tick and tick-index counters with registered PPS/tick.
    always_ff @(posedge clk_tf or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            tick_idx_q  <= '0;
            pps_clean_q <= 1'b1;
            slow_tick_q <= 1'b1;
        end else begin
            sec_cnt_q   <= sec_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_idx_q  <= tick_idx_d;
            pps_clean_q <= pps_clean_next;
            slow_tick_q <= slow_tick_d;
        end
    end

    // A pending stop that crosses TOS marks the new second as having seen its PPS.
    assign seen_carry = (state_q == ARMED) || (state_q == WAIT_TICK) ||
                        ((state_q == IDLE) && pps_rise && !seen_q);

    // Stop FSM plus status flags; later assignments take priority over the ack clear.
    always_ff @(posedge clk_tf or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            guard_q         <= '0;
            seen_q          <= 1'b0;
            stop_tick_idx_q <= '0;
            stop_valid_q    <= 1'b0;
            stop_overrun_q  <= 1'b0;
            pps_missing_q   <= 1'b0;
            pps_extra_q     <= 1'b0;
        end else begin
            if (stop_ack) begin
                stop_valid_q   <= 1'b0;
                stop_overrun_q <= 1'b0;
                pps_extra_q    <= 1'b0;
            end
            if (pps_rise && seen_q) begin
                pps_extra_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pps_rise && !seen_q) begin
                        guard_q <= GUARD_LOAD;
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (guard_q == '0) state_q <= WAIT_TICK;
                    else               guard_q <= guard_q - 1'b1;
                end
                WAIT_TICK: begin
                    if (tick_rise_next) begin
                        stop_tick_idx_q <= stop_idx_next;
                        stop_valid_q    <= 1'b1;
                        if (stop_valid_q && !stop_ack) stop_overrun_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (tos_mark_ddc) state_q <= IDLE;
                end
            endcase
            if (tos_mark_ddc) begin
                pps_missing_q <= !(seen_q || pps_rise);
                seen_q        <= seen_carry;
            end else if (pps_rise) begin
                seen_q <= 1'b1;
            end
        end
    end

    assign tdc_stop_next  = (state_q == WAIT_TICK) && tick_rise_next;
    assign pps_clean_uc   = pps_clean_q;
    assign slow_tick      = slow_tick_q;
    assign stop_tick_idx  = stop_tick_idx_q;
    assign stop_valid     = stop_valid_q;
    assign stop_overrun   = stop_overrun_q;
    assign pps_missing    = pps_missing_q;
    assign pps_extra      = pps_extra_q;
    assign stop_state_dbg = state_q;

endmodule
